v_pipe_update_cmp_pl: RTL and testbench

- Pipelined, parametrised successor to the update-stage key comparator.
- Accepts an update command key plus a snapshot of the current table state.
- Two registered stages return:
  - match one-hot vector, hit flag and full flag;
  - ordered compare mask for bid or ask ordering;
  - encoded insertion position, encoded hit index and a duplicate-key error flag.
- Sits between command decode and the table update/shift logic. Decouples compare timing from the table write path with a valid/ready handshake and full throughput.

---
 rtl/v_pipe_update_cmp_pl_if.sv | 45 ++++
 rtl/v_pipe_update_cmp_pl.sv | 147 ++++++++++++++
 tb/tb_v_pipe_update_cmp_pl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/v_pipe_update_cmp_pl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | v_pipe_update_cmp_pl_if                                                  |
// | Command / response bundle for the pipelined update-stage key comparator. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface v_pipe_update_cmp_pl_if #(
  parameter int ENTRIES_N = 8,
  parameter int KEY_W     = 32,
  parameter int CTX_W     = 8,
  parameter int IDX_W     = $clog2(ENTRIES_N + 1)
);
  logic                         i_cmd_vld;
  logic                         o_cmd_rdy;
  logic [KEY_W-1:0]             i_cmd_key;
  logic [CTX_W-1:0]             i_cmd_ctx;
  logic [ENTRIES_N-1:0]         i_stcur_vld;
  logic [ENTRIES_N*KEY_W-1:0]   i_stcur_keys;
  logic                         i_flush;
  logic                         o_rsp_vld;
  logic                         i_rsp_rdy;
  logic [CTX_W-1:0]             o_rsp_ctx;
  logic                         o_rsp_hit;
  logic                         o_rsp_full;
  logic [ENTRIES_N-1:0]         o_rsp_sel;
  logic [ENTRIES_N-1:0]         o_rsp_mask;
  logic [IDX_W-1:0]             o_rsp_pos;
  logic [IDX_W-1:0]             o_rsp_hit_idx;
  logic                         o_rsp_dup;

  modport master (
    output i_cmd_vld, i_cmd_key, i_cmd_ctx, i_stcur_vld, i_stcur_keys,
           i_flush, i_rsp_rdy,
    input  o_cmd_rdy, o_rsp_vld, o_rsp_ctx, o_rsp_hit, o_rsp_full,
           o_rsp_sel, o_rsp_mask, o_rsp_pos, o_rsp_hit_idx, o_rsp_dup
  );

  modport slave (
    input  i_cmd_vld, i_cmd_key, i_cmd_ctx, i_stcur_vld, i_stcur_keys,
           i_flush, i_rsp_rdy,
    output o_cmd_rdy, o_rsp_vld, o_rsp_ctx, o_rsp_hit, o_rsp_full,
           o_rsp_sel, o_rsp_mask, o_rsp_pos, o_rsp_hit_idx, o_rsp_dup
  );
endinterface
`default_nettype wire

// File: rtl/v_pipe_update_cmp_pl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | v_pipe_update_cmp_pl                                                     |
// | Two-stage key comparator: match vector, ordered mask, position, hit idx. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module v_pipe_update_cmp_pl #(
  parameter int ENTRIES_N    = 8,
  parameter int KEY_W        = 32,
  parameter int CTX_W        = 8,
  parameter int IS_BID_TABLE = 1,
  parameter int IDX_W        = $clog2(ENTRIES_N + 1)
) (
  input  logic                  clk,
  input  logic                  arst,
  v_pipe_update_cmp_pl_if.slave bus
);

  // Pipeline control
  logic w_s2_free;
  logic w_s1_free;
  logic w_s1_adv;
  logic w_accept;

  logic r_s1_vld;
  logic r_s2_vld;

  // S1 captured command and snapshot
  logic [KEY_W-1:0]           r_s1_key;
  logic [CTX_W-1:0]           r_s1_ctx;
  logic [ENTRIES_N-1:0]       r_s1_ent_vld;
  logic [ENTRIES_N*KEY_W-1:0] r_s1_keys;

  // S1 compare results
  logic [ENTRIES_N-1:0] w_eq;
  logic [ENTRIES_N-1:0] w_ord;
  logic [ENTRIES_N-1:0] w_sel;
  logic [ENTRIES_N-1:0] w_mask;
  logic                 w_hit;
  logic                 w_full;

  // Encoded results feeding S2
  logic [IDX_W-1:0]     w_pos;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_dup;

  // S2 registered results
  logic [CTX_W-1:0]     r_s2_ctx;
  logic                 r_s2_hit;
  logic                 r_s2_full;
  logic [ENTRIES_N-1:0] r_s2_sel;
  logic [ENTRIES_N-1:0] r_s2_mask;
  logic [IDX_W-1:0]     r_s2_pos;
  logic [IDX_W-1:0]     r_s2_hit_idx;
  logic                 r_s2_dup;

  assign w_s2_free     = !r_s2_vld | bus.i_rsp_rdy;
  assign w_s1_adv      = r_s1_vld & w_s2_free;
  assign w_s1_free     = !r_s1_vld | w_s2_free;
  assign bus.o_cmd_rdy = !arst & !bus.i_flush & w_s1_free;
  assign w_accept      = bus.i_cmd_vld & bus.o_cmd_rdy;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else if (bus.i_flush) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      if (w_s1_free) begin
        r_s1_vld <= bus.i_cmd_vld;
      end
      if (w_s2_free) begin
        r_s2_vld <= r_s1_vld;
      end
    end
  end

  // Payload registers carry no reset; outputs are gated by the stage valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_key     <= bus.i_cmd_key;
      r_s1_ctx     <= bus.i_cmd_ctx;
      r_s1_ent_vld <= bus.i_stcur_vld;
      r_s1_keys    <= bus.i_stcur_keys;
    end
    if (w_s1_adv) begin
      r_s2_ctx     <= r_s1_ctx;
      r_s2_hit     <= w_hit;
      r_s2_full    <= w_full;
      r_s2_sel     <= w_sel;
      r_s2_mask    <= w_mask;
      r_s2_pos     <= w_pos;
      r_s2_hit_idx <= w_hit_idx;
      r_s2_dup     <= w_dup;
    end
  end

  generate
    for (genvar gi = 0; gi < ENTRIES_N; gi++) begin : g_ent
      logic [KEY_W-1:0] w_ent_key;
      assign w_ent_key = r_s1_keys[gi*KEY_W +: KEY_W];
      assign w_eq[gi]  = (w_ent_key == r_s1_key);
      if (IS_BID_TABLE != 0) begin : g_bid
        assign w_ord[gi] = (w_ent_key > r_s1_key);
      end else begin : g_ask
        assign w_ord[gi] = (w_ent_key < r_s1_key);
      end
      assign w_sel[gi]  = r_s1_ent_vld[gi] & w_eq[gi];
      assign w_mask[gi] = r_s1_ent_vld[gi] & (w_eq[gi] | w_ord[gi]);
    end
  endgenerate

  assign w_hit  = |w_sel;
  assign w_full = &r_s1_ent_vld;
  assign w_dup  = |(w_sel & (w_sel - ENTRIES_N'(1)));

  always_comb begin
    w_pos = '0;
    for (int i = 0; i < ENTRIES_N; i++) begin
      w_pos = w_pos + IDX_W'(w_mask[i]);
    end
  end

  // Scanning downward leaves the lowest matching index in the result.
  always_comb begin
    w_hit_idx = '0;
    for (int i = ENTRIES_N - 1; i >= 0; i--) begin
      if (w_sel[i]) begin
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign bus.o_rsp_vld     = r_s2_vld;
  assign bus.o_rsp_ctx     = r_s2_vld ? r_s2_ctx     : '0;
  assign bus.o_rsp_hit     = r_s2_vld ? r_s2_hit     : 1'b0;
  assign bus.o_rsp_full    = r_s2_vld ? r_s2_full    : 1'b0;
  assign bus.o_rsp_sel     = r_s2_vld ? r_s2_sel     : '0;
  assign bus.o_rsp_mask    = r_s2_vld ? r_s2_mask    : '0;
  assign bus.o_rsp_pos     = r_s2_vld ? r_s2_pos     : '0;
  assign bus.o_rsp_hit_idx = r_s2_vld ? r_s2_hit_idx : '0;
  assign bus.o_rsp_dup     = r_s2_vld ? r_s2_dup     : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_v_pipe_update_cmp_pl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_v_pipe_update_cmp_pl                                                  |
// | Bid and ask instances driven together, checked against a bench model.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_v_pipe_update_cmp_pl;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int CW = 8;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        cmd_vld = 1'b0;
  logic        flush = 1'b0;
  logic        rsp_rdy = 1'b1;
  logic [7:0]  key = '0;
  logic [7:0]  ctx = '0;
  logic [3:0]  svld = '0;
  logic [31:0] skeys = '0;

  always #5 clk = ~clk;

  v_pipe_update_cmp_pl_if #(.ENTRIES_N(N), .KEY_W(KW), .CTX_W(CW)) bus_b ();
  v_pipe_update_cmp_pl_if #(.ENTRIES_N(N), .KEY_W(KW), .CTX_W(CW)) bus_a ();

  assign bus_b.i_cmd_vld = cmd_vld;  assign bus_a.i_cmd_vld = cmd_vld;
  assign bus_b.i_cmd_key = key;      assign bus_a.i_cmd_key = key;
  assign bus_b.i_cmd_ctx = ctx;      assign bus_a.i_cmd_ctx = ctx;
  assign bus_b.i_stcur_vld = svld;   assign bus_a.i_stcur_vld = svld;
  assign bus_b.i_stcur_keys = skeys; assign bus_a.i_stcur_keys = skeys;
  assign bus_b.i_flush = flush;      assign bus_a.i_flush = flush;
  assign bus_b.i_rsp_rdy = rsp_rdy;  assign bus_a.i_rsp_rdy = rsp_rdy;

  v_pipe_update_cmp_pl #(.ENTRIES_N(N), .KEY_W(KW), .CTX_W(CW), .IS_BID_TABLE(1))
    u_bid (.clk(clk), .arst(arst), .bus(bus_b));
  v_pipe_update_cmp_pl #(.ENTRIES_N(N), .KEY_W(KW), .CTX_W(CW), .IS_BID_TABLE(0))
    u_ask (.clk(clk), .arst(arst), .bus(bus_a));

  typedef struct packed {
    logic [7:0] ctx;
    logic       hit;
    logic       full;
    logic [3:0] sel;
    logic [3:0] mask;
    logic [2:0] pos;
    logic [2:0] hidx;
    logic       dup;
  } exp_t;

  exp_t fifo [2][16];
  int   acc  [2][16];
  int   rd [2] = '{0, 0};
  int   wr [2] = '{0, 0};
  int   rsp_cnt [2] = '{0, 0};
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference: straight from the ordering rules, entry by entry.
  function automatic exp_t model(input logic [7:0] k, input logic [7:0] c,
                                 input logic [3:0] v, input logic [31:0] ks,
                                 input bit bid);
    exp_t e;
    int   n_eq;
    int   n_keep;
    bit   found;
    e = '0; n_eq = 0; n_keep = 0; found = 0;
    e.ctx = c;
    for (int i = 0; i < N; i++) begin
      logic [7:0] ek;
      ek = ks[i*8 +: 8];
      if (v[i]) begin
        if (ek == k) begin
          e.sel[i] = 1'b1;
          n_eq++;
          if (!found) begin
            e.hidx = 3'(i);
            found = 1;
          end
        end
        if (ek == k || (bid ? (ek > k) : (ek < k))) begin
          e.mask[i] = 1'b1;
          n_keep++;
        end
      end
    end
    e.hit  = (n_eq > 0);
    e.dup  = (n_eq > 1);
    e.pos  = 3'(n_keep);
    e.full = (v == 4'hF);
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] c, input logic h, input logic f,
                              input logic [3:0] s, input logic [3:0] m,
                              input logic [2:0] p, input logic [2:0] hi,
                              input logic d);
    exp_t e;
    e = '{ctx: c, hit: h, full: f, sel: s, mask: m, pos: p, hidx: hi, dup: d};
    return e;
  endfunction

  function automatic exp_t dut_rsp(input int d);
    if (d == 0)
      return mk(bus_b.o_rsp_ctx, bus_b.o_rsp_hit, bus_b.o_rsp_full, bus_b.o_rsp_sel,
                bus_b.o_rsp_mask, bus_b.o_rsp_pos, bus_b.o_rsp_hit_idx, bus_b.o_rsp_dup);
    return mk(bus_a.o_rsp_ctx, bus_a.o_rsp_hit, bus_a.o_rsp_full, bus_a.o_rsp_sel,
              bus_a.o_rsp_mask, bus_a.o_rsp_pos, bus_a.o_rsp_hit_idx, bus_a.o_rsp_dup);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_dut(input int d);
    string tag;
    logic  rv;
    logic  rdy;
    logic  exp_rv;
    int    n;
    tag = (d == 0) ? "bid" : "ask";
    rv  = (d == 0) ? bus_b.o_rsp_vld : bus_a.o_rsp_vld;
    rdy = (d == 0) ? bus_b.o_cmd_rdy : bus_a.o_cmd_rdy;
    if (arst) begin
      chk({tag, "_rst_out"}, {rv, rdy, dut_rsp(d)}, '0);
      rd[d] = 0; wr[d] = 0;
      return;
    end
    n = wr[d] - rd[d];
    exp_rv = (n > 0) && ((cyc - acc[d][rd[d] % 16]) >= 2);
    chk({tag, "_rsp_vld"}, rv, exp_rv);
    chk({tag, "_cmd_rdy"}, rdy, !flush && !(n == 2 && !rsp_rdy));
    if (exp_rv) begin
      chk({tag, "_rsp"}, dut_rsp(d), fifo[d][rd[d] % 16]);
      if (rsp_rdy) begin
        rd[d]++;
        rsp_cnt[d]++;
      end
    end else begin
      chk({tag, "_idle_out"}, dut_rsp(d), '0);
    end
    if (flush) begin
      rd[d] = wr[d];
    end else if (cmd_vld && rdy) begin
      fifo[d][wr[d] % 16] = model(key, ctx, svld, skeys, d == 0);
      acc[d][wr[d] % 16]  = cyc;
      wr[d]++;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    check_dut(0);
    check_dut(1);
  end

  task automatic send(input logic [7:0] k, input logic [7:0] c,
                      input logic [3:0] v, input logic [31:0] ks);
    bit done;
    done = 0;
    key = k; ctx = c; svld = v; skeys = ks; cmd_vld = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = bus_b.o_cmd_rdy;
      @(posedge clk);
      #1;
    end
    cmd_vld = 1'b0;
    // Scramble the snapshot: in-flight commands must not see it.
    svld  = 4'($urandom);
    skeys = $urandom;
    chk("send_accepted", {31'd0, done}, 32'd1);
  endtask

  // Result expected two negedges after acceptance, on instance d.
  task automatic lit(input int d, input string nm, input exp_t e);
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_vld"}, (d == 0) ? bus_b.o_rsp_vld : bus_a.o_rsp_vld, 1);
    chk(nm, dut_rsp(d), e);
  endtask

  localparam logic [31:0] KEYS1 = 32'h10206050;
  localparam logic [31:0] KEYS3 = 32'h40409080;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Pin the model against hand-derived results.
    chk("pin_t1", model(8'h50, 8'h01, 4'b0011, KEYS1, 1), mk(8'h01, 1, 0, 4'b0001, 4'b0011, 3'd2, 3'd0, 0));
    chk("pin_t2a", model(8'h55, 8'h03, 4'b0011, KEYS1, 0), mk(8'h03, 0, 0, 4'b0000, 4'b0001, 3'd1, 3'd0, 0));
    chk("pin_t2b", model(8'h70, 8'h04, 4'b0011, KEYS1, 0), mk(8'h04, 0, 0, 4'b0000, 4'b0011, 3'd2, 3'd0, 0));
    chk("pin_t3", model(8'h40, 8'h05, 4'b1111, KEYS3, 1), mk(8'h05, 1, 1, 4'b1100, 4'b1111, 3'd4, 3'd2, 1));

    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    chk("reset_rdy", bus_b.o_cmd_rdy, 1);
    chk("reset_rsp_vld", bus_b.o_rsp_vld, 0);
    @(posedge clk); #1;

    // Directed single commands
    send(8'h50, 8'h01, 4'b0011, KEYS1);
    lit(0, "t1_bid", mk(8'h01, 1, 0, 4'b0001, 4'b0011, 3'd2, 3'd0, 0));
    send(8'h45, 8'h02, 4'b0011, KEYS1);
    lit(1, "t2_ask_45", mk(8'h02, 0, 0, 4'b0000, 4'b0000, 3'd0, 3'd0, 0));
    send(8'h55, 8'h03, 4'b0011, KEYS1);
    lit(1, "t2_ask_55", mk(8'h03, 0, 0, 4'b0000, 4'b0001, 3'd1, 3'd0, 0));
    send(8'h70, 8'h04, 4'b0011, KEYS1);
    lit(1, "t2_ask_70", mk(8'h04, 0, 0, 4'b0000, 4'b0011, 3'd2, 3'd0, 0));
    send(8'h40, 8'h05, 4'b1111, KEYS3);
    lit(0, "t3_dup", mk(8'h05, 1, 1, 4'b1100, 4'b1111, 3'd4, 3'd2, 1));
    send(8'h50, 8'h06, 4'b0000, 32'h50505050);
    lit(0, "empty", mk(8'h06, 0, 0, 4'b0000, 4'b0000, 3'd0, 3'd0, 0));
    send(8'h05, 8'h07, 4'b1111, KEYS1);
    lit(0, "below_all", mk(8'h07, 0, 1, 4'b0000, 4'b1111, 3'd4, 3'd0, 0));
    send(8'h77, 8'h08, 4'b0101, 32'h77777777);
    lit(0, "invalid_ent", mk(8'h08, 1, 0, 4'b0101, 4'b0101, 3'd2, 3'd0, 1));
    @(posedge clk); #1;

    // Back-to-back stream with a 3-cycle stall
    base = rsp_cnt[0];
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(8'($urandom), 8'(i), 4'($urandom), $urandom);
      end
      begin
        repeat (3) @(posedge clk);
        #1 rsp_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rsp_rdy = 1'b1;
      end
    join
    for (int t = 0; t < 20 && rd[0] != wr[0]; t++) @(posedge clk);
    #1;
    chk("stream_count", rsp_cnt[0] - base, 8);

    // Flush with both stages occupied
    rsp_rdy = 1'b0;
    send(8'h11, 8'h20, 4'b1111, KEYS3);
    send(8'h22, 8'h21, 4'b1111, KEYS3);
    key = 8'h33; ctx = 8'h22; cmd_vld = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_rdy", bus_b.o_cmd_rdy, 0);
    @(posedge clk); #1;
    flush = 1'b0; cmd_vld = 1'b0; rsp_rdy = 1'b1;
    @(negedge clk);
    chk("flush_rsp_vld", bus_b.o_rsp_vld, 0);
    @(posedge clk); #1;
    send(8'h90, 8'h23, 4'b1111, KEYS3);
    lit(0, "post_flush", mk(8'h23, 1, 1, 4'b0010, 4'b0010, 3'd1, 3'd1, 0));
    @(posedge clk); #1;

    // Asynchronous reset with both stages occupied
    rsp_rdy = 1'b0;
    send(8'h11, 8'h30, 4'b1111, KEYS3);
    send(8'h22, 8'h31, 4'b1111, KEYS3);
    chk("pre_rst_vld", bus_b.o_rsp_vld, 1);
    #1 arst = 1'b1;
    #1;
    chk("async_rst_vld", {bus_b.o_rsp_vld, bus_a.o_rsp_vld}, 0);
    chk("async_rst_rdy", bus_b.o_cmd_rdy, 0);
    @(posedge clk); #1;
    arst = 1'b0; rsp_rdy = 1'b1;
    send(8'h50, 8'h32, 4'b0011, KEYS1);
    lit(0, "post_rst", mk(8'h32, 1, 0, 4'b0001, 4'b0011, 3'd2, 3'd0, 0));
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
